seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Sequential restoring divider, one quotient bit per clock. It is the inverse
//   operation of the Booth sequential multiplier and shares its operand width.
//   Sits beside the multiplier datapath and feeds the same BCD display path.
//   The block contains its own control FSM, iteration counter and partial-remainder datapath.
// PARAMETERS
//   WIDTH  5  operand/result width in bits (>=2); iteration count = WIDTH
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      reset, asynchronous, active-high
//   start        in   1      request; sampled only in S_IDLE
//   dividend     in   WIDTH  numerator; latched on the accepted start edge
//   divisor      in   WIDTH  denominator; latched on the accepted start edge
//   quotient     out  WIDTH  result; registered, held until next accepted start
//   remainder    out  WIDTH  result; registered, held until next accepted start
//   busy         out  1      high in every state except S_IDLE
//   done         out  1      one-cycle pulse in S_DONE; results valid from this cycle
//   div_by_zero  out  1      registered; set with done when divisor==0; cleared on next start
// BEHAVIOUR
//   Reset: state=S_IDLE; quotient, remainder, busy, done, div_by_zero all 0; counter 0.
//   States:
//   - S_IDLE: start=1 -> latch operands, clear div_by_zero -> S_CHECK. start=0 -> stay.
//   - S_CHECK: divisor==0 -> quotient=all ones, remainder=dividend, div_by_zero=1 -> S_DONE.
//     Otherwise: P=0 (WIDTH+1 bits), Q=|dividend|, D=|divisor|, counter=WIDTH-1 -> S_STEP.
//   - S_STEP: {P,Q} <<= 1; T=P-D (WIDTH+1 bits).
//     If T>=0: P=T and Q[0]=1. Otherwise: P unchanged and Q[0]=0.
//     counter==0 -> S_FIX; otherwise counter-1 and stay in S_STEP.
//   - S_FIX: apply sign correction (see CONFIGURATION), register quotient/remainder -> S_DONE.
//   - S_DONE: done=1 for exactly one cycle -> S_IDLE.
//   Latency, counted in clock edges from the start-sampling edge to done going high:
//   - normal division: WIDTH+3 edges (8 for WIDTH=5);
//   - divide-by-zero: 2 edges.
//   Boundary and timing rules:
//   - start while busy (any state other than S_IDLE, including S_DONE) is ignored; no queueing.
//   - start held high continuously -> a new operation begins on the edge after S_DONE
//     (back-to-back operation).
//   - Operand inputs may change freely after the accepted edge; the block uses only the
//     latched copies.
//   - rst asserted mid-operation -> immediate return to the reset values; no done pulse
//     for the aborted operation.
//   - Outputs update only in S_CHECK (divide-by-zero) or S_FIX; they never change
//     during S_STEP.
//   - Illegal state encoding -> S_IDLE on the next edge.
// CONFIGURATION
//   SEQ_DIV_SIGNED_EN
//   - Undefined: operands and results are unsigned; |x| = x; S_FIX copies Q and P[WIDTH-1:0].
//   - Defined: operands and results are two's complement.
//     - The quotient truncates toward zero.
//     - Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
//     - Overflow case (most-negative / -1): quotient = most-negative (wraps), remainder = 0,
//       div_by_zero = 0.
//     - Divide-by-zero output is unchanged: quotient all ones, remainder = dividend.
// TESTING (WIDTH=5)
//   1. unsigned 23/4 -> quotient=5, remainder=3, done exactly 8 edges after start,
//      busy high for 8 cycles.
//   2. 9/0 -> div_by_zero=1, quotient=5'b11111, remainder=9, done 2 edges after start;
//      next start 6/3 -> div_by_zero=0, quotient=2, remainder=0.
//   3. start 31/1, then pulse start again with 4/2 while busy -> second start ignored;
//      quotient=31, remainder=0, single done pulse.
//   4. start 20/3, assert rst after 3 edges -> all outputs 0, S_IDLE, no done;
//      a following 20/3 gives quotient=6, remainder=2.
//   5. start held high, operands 7/2 -> done pulses every 9 cycles;
//      quotient=3, remainder=1 each time.
//   6. SEQ_DIV_SIGNED_EN defined:
//      - -13/4 -> quotient=5'b11101 (-3), remainder=5'b11111 (-1);
//      - -16/-1 -> quotient=5'b10000, remainder=0, div_by_zero=0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Sequential restoring divider producing one quotient bit per clock.
//   A small FSM latches the operands on an accepted start, detects a zero
//   divisor, iterates WIDTH shift/subtract steps on a partial remainder and
//   then registers the final quotient and remainder.
//
//   Optional feature macro: SEQ_DIV_SIGNED_EN
//     undefined -> unsigned operands and results
//     defined   -> two's complement operands, quotient truncated toward zero,
//                  remainder carries the dividend's sign
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      operation request, only looked at while idle
//   dividend     in   WIDTH  numerator, captured on the accepted start edge
//   divisor      in   WIDTH  denominator, captured on the accepted start edge
//   quotient     out  WIDTH  registered result
//   remainder    out  WIDTH  registered result
//   busy         out  1      high whenever the FSM is not idle
//   done         out  1      one-cycle pulse, results valid from this cycle
//   div_by_zero  out  1      set together with done for a zero divisor
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_STEP  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  // The partial remainder always ends a step below D, so WIDTH bits hold it;
  // only the shifted value needs the extra bit.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] t_diff;
  logic             t_ge;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH-1:0] quot_fix, rem_fix;

`ifdef SEQ_DIV_SIGNED_EN
  // Magnitudes feed the unsigned core. The most negative value maps onto
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  always_comb begin
    dividend_abs = dividend_q[WIDTH-1] ? -dividend_q : dividend_q;
    divisor_abs  = divisor_q[WIDTH-1]  ? -divisor_q  : divisor_q;
    quot_fix     = (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]) ? -q_q : q_q;
    rem_fix      = dividend_q[WIDTH-1] ? -p_q : p_q;
  end
`else
  assign dividend_abs = dividend_q;
  assign divisor_abs  = divisor_q;
  assign quot_fix     = q_q;
  assign rem_fix      = p_q;
`endif

  // One restoring step: shift {P,Q} left and trial-subtract D.
  assign p_shift = {p_q, q_q[WIDTH-1]};
  assign t_ge    = (p_shift >= {1'b0, d_q});
  // When the subtraction succeeds the result is below D, so the low bits suffice.
  assign t_diff  = p_shift[WIDTH-1:0] - d_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          dbz_d      = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          p_d     = '0;
          q_d     = dividend_abs;
          d_d     = divisor_abs;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (t_ge) begin
          p_d = t_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = p_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        quotient_d  = quot_fix;
        remainder_d = rem_fix;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Directed bench for seq_restoring_divider (WIDTH=5). A behavioural model
//   tracks accepted operations by their latency and the arithmetic result;
//   a compare process checks every output on every falling edge, and the
//   directed tasks pin results and latencies with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  function automatic res_t model_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    int   ia;
    int   ib;
    if (b == '0) begin
      res.q = '1;
      res.r = a;
      res.z = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      ia = $signed(a);
      ib = $signed(b);
`else
      ia = int'(a);
      ib = int'(b);
`endif
      res.q = W'(ia / ib);
      res.r = W'(ia % ib);
      res.z = 1'b0;
    end
    return res;
  endfunction

  // m_cnt: cycles left until the done cycle is over (0 = idle, 1 = done cycle)
  int   m_cnt = 0;
  res_t m_pend = '0;
  res_t m_out = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_out = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend  = model_div(dividend, divisor);
        m_cnt   = (divisor == '0) ? 2 : W + 3;
        m_out.z = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) m_out = m_pend;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", busy, (m_cnt != 0));
    chk("cyc_done", done, (m_cnt == 1));
    chk("cyc_quotient", quotient, m_out.q);
    chk("cyc_remainder", remainder, m_out.r);
    chk("cyc_div_by_zero", div_by_zero, m_out.z);
  end

  // ---------------- directed stimulus ----------------
  // Called on a falling edge. Issues one operation and checks literal results.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int elat, input bit interfere);
    int lat;
    int busy_n;
    int d0;
    d0       = done_cnt;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 1;
    busy_n   = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (interfere) begin
        start = (lat == 3);
        if (lat == 3) begin
          dividend = 5'd4;
          divisor  = 5'd2;
        end
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy === 1'b1) busy_n++;
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, busy_n, elat);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_by_zero"}, div_by_zero, ez);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d latency=%0d",
             tag, a, b, quotient, remainder, div_by_zero, lat);
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  // 23=-9, 31=-1, 20=-12 when read as 5-bit two's complement
  localparam logic [W-1:0] T1_Q = 5'b11110, T1_R = 5'b11111;
  localparam logic [W-1:0] T3_Q = 5'b11111, T3_R = 5'd0;
  localparam logic [W-1:0] T4_Q = 5'b11100, T4_R = 5'd0;
`else
  localparam logic [W-1:0] T1_Q = 5'd5,  T1_R = 5'd3;
  localparam logic [W-1:0] T3_Q = 5'd31, T3_R = 5'd0;
  localparam logic [W-1:0] T4_Q = 5'd6,  T4_R = 5'd2;
`endif

  initial begin
    int t[3];
    int n;
    int guard;
    int d0;
    t        = '{0, 0, 0};
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_quotient", quotient, 5'd0);
    chk("reset_remainder", remainder, 5'd0);
    chk("reset_div_by_zero", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1_23_4", 5'd23, 5'd4, T1_Q, T1_R, 1'b0, 8, 1'b0);
    run_op("t2_9_0", 5'd9, 5'd0, 5'b11111, 5'd9, 1'b1, 2, 1'b0);
    run_op("t2_6_3", 5'd6, 5'd3, 5'd2, 5'd0, 1'b0, 8, 1'b0);
    run_op("t3_31_1", 5'd31, 5'd1, T3_Q, T3_R, 1'b0, 8, 1'b1);

    // Abort mid-operation with the asynchronous reset.
    d0       = done_cnt;
    start    = 1'b1;
    dividend = 5'd20;
    divisor  = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_done", done, 1'b0);
    chk("t4_rst_quotient", quotient, 5'd0);
    chk("t4_rst_remainder", remainder, 5'd0);
    chk("t4_rst_div_by_zero", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_no_done_after_abort", done_cnt - d0, 0);
    $display("op t4_abort: reset during 20 / 3, done pulses=%0d", done_cnt - d0);
    run_op("t4_20_3", 5'd20, 5'd3, T4_Q, T4_R, 1'b0, 8, 1'b0);

    // Back-to-back with start held high.
    start    = 1'b1;
    dividend = 5'd7;
    divisor  = 5'd2;
    n        = 0;
    guard    = 0;
    while (n < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (done === 1'b1) begin
        t[n] = cyc;
        chk("t5_quotient", quotient, 5'd3);
        chk("t5_remainder", remainder, 5'd1);
        $display("op t5_b2b: 7 / 2 -> q=%0d r=%0d at cycle %0d", quotient, remainder, cyc);
        n++;
      end
    end
    chk("t5_pulse_count", n, 3);
    chk("t5_period_a", t[1] - t[0], 9);
    chk("t5_period_b", t[2] - t[1], 9);
    start = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t5_returns_idle", busy, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
    run_op("s_m13_4", 5'b10011, 5'd4, 5'b11101, 5'b11111, 1'b0, 8, 1'b0);
    run_op("s_m16_m1", 5'b10000, 5'b11111, 5'b10000, 5'd0, 1'b0, 8, 1'b0);
    run_op("s_7_m2", 5'd7, 5'b11110, 5'b11101, 5'd1, 1'b0, 8, 1'b0);
    run_op("s_m7_0", 5'b11001, 5'd0, 5'b11111, 5'b11001, 1'b1, 2, 1'b0);
`else
    run_op("u_0_31", 5'd0, 5'd31, 5'd0, 5'd0, 1'b0, 8, 1'b0);
    run_op("u_31_31", 5'd31, 5'd31, 5'd1, 5'd0, 1'b0, 8, 1'b0);
    run_op("u_5_7", 5'd5, 5'd7, 5'd0, 5'd5, 1'b0, 8, 1'b0);
    run_op("u_30_16", 5'd30, 5'd16, 5'd1, 5'd14, 1'b0, 8, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
